// File: rtl/square_arb_pkg.sv
// Shared types and widths for the round-robin squaring arbiter.
package square_arb_pkg;

  localparam int DEF_NREQ = 4;
  localparam int OPW      = 4;
  localparam int RESW     = 8;
  localparam int CNTW     = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arbState_e;

endpackage

// File: rtl/square_arbiter_if.sv
// Request/response bundle between client blocks and the squaring arbiter.
interface square_arbiter_if
  import square_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]     req_valid;
  logic [OPW*NREQ-1:0] req_din;
  logic [NREQ-1:0]     req_ready;
  logic                resp_valid;
  logic                resp_ready;
  logic [IDW-1:0]      resp_id;
  logic [RESW-1:0]     resp_dout;
  logic [CNTW-1:0]     done_cnt;

  modport slave (
    input  req_valid, req_din, resp_ready,
    output req_ready, resp_valid, resp_id, resp_dout, done_cnt
  );

  modport master (
    output req_valid, req_din, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_dout, done_cnt
  );

endinterface

// File: rtl/square.sv
// Combinational 4-bit squarer; the full 8-bit product is kept.
module square
  import square_arb_pkg::*;
(
  input  logic [OPW-1:0]  din_i,
  output logic [RESW-1:0] dout_o
);

  assign dout_o = {{(RESW-OPW){1'b0}}, din_i} * {{(RESW-OPW){1'b0}}, din_i};

endmodule

// File: rtl/square_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            valid_o
);

  int   cand;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_i) + k) % NREQ;
      if (en_i && !found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDW'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/square_arbiter.sv
// Shares one squarer among NREQ valid/ready requesters; registered, tagged result.
module square_arbiter
  import square_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  square_arbiter_if.slave bus
);

  arbState_e       state_q, state_d;
  logic [IDW-1:0]  rrPtr_q, rrPtr_d;
  logic            respValid_q, respValid_d;
  logic [IDW-1:0]  respId_q, respId_d;
  logic [RESW-1:0] respDout_q, respDout_d;
  logic [CNTW-1:0] doneCnt_q, doneCnt_d;

  logic            acceptAllowed;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grantIdx;
  logic            accept;
  logic            handshake;
  logic [OPW-1:0]  operand;
  logic [RESW-1:0] sqOut;

  // New work is taken when idle, or in HOLD when the current result leaves this cycle.
  assign acceptAllowed = !rst && ((state_q == IDLE) || (state_q == HOLD && bus.resp_ready));
  assign handshake     = respValid_q && bus.resp_ready;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i   (bus.req_valid),
    .ptr_i   (rrPtr_q),
    .en_i    (acceptAllowed),
    .grant_o (grant),
    .idx_o   (grantIdx),
    .valid_o (accept)
  );

  always_comb begin
    operand = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grantIdx == IDW'(i)) operand = bus.req_din[i*OPW +: OPW];
    end
  end

  square u_square (
    .din_i  (operand),
    .dout_o (sqOut)
  );

  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    respValid_d = respValid_q;
    respId_d    = respId_q;
    respDout_d  = respDout_q;
    doneCnt_d   = doneCnt_q + (handshake ? CNTW'(1) : CNTW'(0));
    case (state_q)
      IDLE: begin
        if (accept) state_d = HOLD;
      end
      HOLD: begin
        if (bus.resp_ready && !accept) begin
          state_d     = IDLE;
          respValid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      respValid_d = 1'b1;
      respId_d    = grantIdx;
      respDout_d  = sqOut;
      rrPtr_d     = (grantIdx == IDW'(NREQ-1)) ? '0 : grantIdx + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rrPtr_q     <= '0;
      respValid_q <= 1'b0;
      respId_q    <= '0;
      respDout_q  <= '0;
      doneCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      respValid_q <= respValid_d;
      respId_q    <= respId_d;
      respDout_q  <= respDout_d;
      doneCnt_q   <= doneCnt_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = respValid_q;
  assign bus.resp_id    = respId_q;
  assign bus.resp_dout  = respDout_q;
  assign bus.done_cnt   = doneCnt_q;

endmodule

// File: tb/tb_square_arbiter.sv
// Directed scenario bench for square_arbiter with four requesters.
module tb_square_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  square_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

  square_arbiter #(.NREQ(4), .IDW(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] din, input logic ready);
    bus.req_valid  = valid;
    bus.req_din    = din;
    bus.resp_ready = ready;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(4'b1111, 16'h1234, 1'b1);
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ready: got %b expected %b", bus.req_ready, 4'b0000); end
    step();
    step();
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ready2: got %b expected %b", bus.req_ready, 4'b0000); end
    rst = 1'b0;
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.resp_valid); end
    total++; if (bus.resp_id !== 2'd0) begin bad++; $display("[TB] FAIL reset_id: got %0d expected 0", bus.resp_id); end
    total++; if (bus.resp_dout !== 8'd0) begin bad++; $display("[TB] FAIL reset_dout: got %0d expected 0", bus.resp_dout); end
    total++; if (bus.done_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d expected 0", bus.done_cnt); end
  endtask

  task automatic test_single();
    applyStimulus(4'b0001, 16'h000D, 1'b1);
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL single_ready: got %b expected 0001", bus.req_ready); end
    step();
    applyStimulus(4'b0000, 16'h0000, 1'b1);
    total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid: got %b expected 1", bus.resp_valid); end
    total++; if (bus.resp_id !== 2'd0) begin bad++; $display("[TB] FAIL single_id: got %0d expected 0", bus.resp_id); end
    total++; if (bus.resp_dout !== 8'd169) begin bad++; $display("[TB] FAIL single_dout: got %0d expected 169", bus.resp_dout); end
    step();
    total++; if (bus.done_cnt !== 16'd1) begin bad++; $display("[TB] FAIL single_cnt: got %0d expected 1", bus.done_cnt); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_idle: got %b expected 0", bus.resp_valid); end
  endtask

  task automatic test_round_robin();
    int          rrDout[4] = '{9, 25, 49, 225};
    logic [3:0]  expReady;
    doReset();
    applyStimulus(4'b1111, 16'hF753, 1'b1);
    for (int k = 0; k < 8; k++) begin
      expReady = 4'b0001 << (k % 4);
      total++; if (bus.req_ready !== expReady) begin bad++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, bus.req_ready, expReady); end
      step();
      total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL rr_valid[%0d]: got %b expected 1", k, bus.resp_valid); end
      total++; if (int'(bus.resp_id) !== (k % 4)) begin bad++; $display("[TB] FAIL rr_id[%0d]: got %0d expected %0d", k, bus.resp_id, k % 4); end
      total++; if (int'(bus.resp_dout) !== rrDout[k % 4]) begin bad++; $display("[TB] FAIL rr_dout[%0d]: got %0d expected %0d", k, bus.resp_dout, rrDout[k % 4]); end
      total++; if (int'(bus.done_cnt) !== k) begin bad++; $display("[TB] FAIL rr_cnt[%0d]: got %0d expected %0d", k, bus.done_cnt, k); end
    end
    applyStimulus(4'b0000, 16'h0000, 1'b1);
    step();
    total++; if (bus.done_cnt !== 16'd8) begin bad++; $display("[TB] FAIL rr_cnt_end: got %0d expected 8", bus.done_cnt); end
  endtask

  task automatic test_backpressure();
    doReset();
    applyStimulus(4'b0110, 16'h0290, 1'b0);
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL bp_first_ready: got %b expected 0010", bus.req_ready); end
    step();
    for (int k = 0; k < 5; k++) begin
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 0000", k, bus.req_ready); end
      total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", k, bus.resp_valid); end
      total++; if (bus.resp_dout !== 8'd81) begin bad++; $display("[TB] FAIL bp_dout[%0d]: got %0d expected 81", k, bus.resp_dout); end
      total++; if (bus.resp_id !== 2'd1) begin bad++; $display("[TB] FAIL bp_id[%0d]: got %0d expected 1", k, bus.resp_id); end
      step();
    end
    total++; if (bus.done_cnt !== 16'd0) begin bad++; $display("[TB] FAIL bp_cnt_held: got %0d expected 0", bus.done_cnt); end
    applyStimulus(4'b0110, 16'h0290, 1'b1);
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("[TB] FAIL bp_release_ready: got %b expected 0100", bus.req_ready); end
    step();
    total++; if (bus.resp_id !== 2'd2) begin bad++; $display("[TB] FAIL bp_next_id: got %0d expected 2", bus.resp_id); end
    total++; if (bus.resp_dout !== 8'd4) begin bad++; $display("[TB] FAIL bp_next_dout: got %0d expected 4", bus.resp_dout); end
    total++; if (bus.done_cnt !== 16'd1) begin bad++; $display("[TB] FAIL bp_next_cnt: got %0d expected 1", bus.done_cnt); end
    applyStimulus(4'b0000, 16'h0000, 1'b1);
    step();
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain_valid: got %b expected 0", bus.resp_valid); end
    total++; if (bus.done_cnt !== 16'd2) begin bad++; $display("[TB] FAIL bp_drain_cnt: got %0d expected 2", bus.done_cnt); end
  endtask

  task automatic test_pointer_skip();
    doReset();
    applyStimulus(4'b0001, 16'h0002, 1'b1);
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL skip_first_ready: got %b expected 0001", bus.req_ready); end
    step();
    applyStimulus(4'b1001, 16'hA006, 1'b1);
    total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("[TB] FAIL skip_ready3: got %b expected 1000", bus.req_ready); end
    step();
    total++; if (bus.resp_id !== 2'd3) begin bad++; $display("[TB] FAIL skip_id3: got %0d expected 3", bus.resp_id); end
    total++; if (bus.resp_dout !== 8'd100) begin bad++; $display("[TB] FAIL skip_dout3: got %0d expected 100", bus.resp_dout); end
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL skip_ready0: got %b expected 0001", bus.req_ready); end
    step();
    total++; if (bus.resp_id !== 2'd0) begin bad++; $display("[TB] FAIL skip_id0: got %0d expected 0", bus.resp_id); end
    total++; if (bus.resp_dout !== 8'd36) begin bad++; $display("[TB] FAIL skip_dout0: got %0d expected 36", bus.resp_dout); end
    applyStimulus(4'b0000, 16'h0000, 1'b1);
    step();
  endtask

  task automatic test_reset_mid();
    doReset();
    applyStimulus(4'b0001, 16'h0001, 1'b1);
    step();
    applyStimulus(4'b0100, 16'h0B00, 1'b1);
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("[TB] FAIL mid_b2b_ready: got %b expected 0100", bus.req_ready); end
    step();
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    step();
    total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_hold_valid: got %b expected 1", bus.resp_valid); end
    total++; if (bus.resp_dout !== 8'd121) begin bad++; $display("[TB] FAIL mid_hold_dout: got %0d expected 121", bus.resp_dout); end
    total++; if (bus.done_cnt !== 16'd1) begin bad++; $display("[TB] FAIL mid_hold_cnt: got %0d expected 1", bus.done_cnt); end
    rst = 1'b1;
    applyStimulus(4'b1111, 16'h1111, 1'b1);
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL mid_rst_ready: got %b expected 0000", bus.req_ready); end
    step();
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", bus.resp_valid); end
    total++; if (bus.done_cnt !== 16'd0) begin bad++; $display("[TB] FAIL mid_rst_cnt: got %0d expected 0", bus.done_cnt); end
    rst = 1'b0;
    applyStimulus(4'b0000, 16'h0000, 1'b1);
    step();
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_no_stale: got %b expected 0", bus.resp_valid); end
    applyStimulus(4'b1111, 16'h4321, 1'b1);
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL mid_ptr_zero: got %b expected 0001", bus.req_ready); end
    step();
    total++; if (bus.resp_id !== 2'd0) begin bad++; $display("[TB] FAIL mid_after_id: got %0d expected 0", bus.resp_id); end
    total++; if (bus.resp_dout !== 8'd1) begin bad++; $display("[TB] FAIL mid_after_dout: got %0d expected 1", bus.resp_dout); end
    applyStimulus(4'b0000, 16'h0000, 1'b1);
    step();
  endtask

  task automatic test_datapath();
    int          sq[16] = '{0, 1, 4, 9, 16, 25, 36, 49, 64, 81, 100, 121, 144, 169, 196, 225};
    logic [15:0] dv;
    doReset();
    for (int d = 0; d < 16; d++) begin
      dv = 16'(d) << 8;
      applyStimulus(4'b0100, dv, 1'b1);
      step();
      total++; if (int'(bus.resp_dout) !== sq[d]) begin bad++; $display("[TB] FAIL dp_dout[%0d]: got %0d expected %0d", d, bus.resp_dout, sq[d]); end
      total++; if (bus.resp_id !== 2'd2) begin bad++; $display("[TB] FAIL dp_id[%0d]: got %0d expected 2", d, bus.resp_id); end
    end
    applyStimulus(4'b0000, 16'h0000, 1'b1);
    step();
    total++; if (bus.done_cnt !== 16'd16) begin bad++; $display("[TB] FAIL dp_cnt: got %0d expected 16", bus.done_cnt); end
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_din    = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_reset_mid();
    test_datapath();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
